// File: rtl/gol_gen_scheduler.sv
// Generation scheduler for the Game of Life engine, clocked from the system clock.
// Latency: a scheduled generation starts 1 clk after the vsync tick; sweep is 2*2**CELL_BITS+2 cycles.
// Backpressure: none; frame ticks that arrive while a load or sweep is in progress are dropped.
module gol_gen_scheduler #(
    parameter int CELL_BITS  = 6,
    parameter int SPEED_BITS = 4,
    parameter int GEN_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vsync,
    input  logic                  run_n,
    input  logic                  step,
    input  logic                  pattern_rst,
    input  logic [SPEED_BITS-1:0] speed,
    output logic [CELL_BITS-1:0]  cell_idx,
    output logic [CELL_BITS-1:0]  lookahead_idx,
    output logic                  load_en,
    output logic                  copy_en,
    output logic                  compute_en,
    output logic                  vga_source,
    output logic [GEN_BITS-1:0]   generation,
    output logic [1:0]            bg_tracker,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COPY    = 3'd2,
        S_PRIME   = 3'd3,
        S_COMPUTE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CELL_BITS-1:0]  IDX_MAX = '1;
    localparam logic [CELL_BITS-1:0]  IDX_ONE = 1;
    localparam logic [SPEED_BITS-1:0] FC_ONE  = 1;
    localparam logic [GEN_BITS-1:0]   GEN_ONE = 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [CELL_BITS-1:0]   idx;
    logic [SPEED_BITS-1:0]  frame_cnt;
    logic                   vsync_q;
    logic                   step_q;
    logic                   step_pend;
    logic                   init_pend;
    logic                   tick;
    logic                   step_edge;
    logic                   reload_req;
    logic                   idle_tick;

    assign tick       = vsync & ~vsync_q;
    assign step_edge  = step & ~step_q;
    assign reload_req = pattern_rst | init_pend;
    assign idle_tick  = (state == S_IDLE) && tick;

    // Next-state selection: ticks only matter in IDLE, sweeps run to completion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    if (reload_req) begin
                        state_nxt = S_LOAD;
                    end else if (!run_n) begin
                        if (frame_cnt == speed) begin
                            state_nxt = S_COPY;
                        end
                    end else if (step_pend) begin
                        state_nxt = S_COPY;
                    end
                end
            end
            S_LOAD:    state_nxt = S_IDLE;
            S_COPY:    state_nxt = (idx == IDX_MAX) ? S_PRIME : S_COPY;
            S_PRIME:   state_nxt = S_COMPUTE;
            S_COMPUTE: state_nxt = (idx == IDX_MAX) ? S_DONE : S_COMPUTE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Engine controls decoded from state and sweep index; lookahead runs one cell ahead in COMPUTE.
    always_comb begin
        cell_idx      = '0;
        lookahead_idx = '0;
        load_en       = 1'b0;
        copy_en       = 1'b0;
        compute_en    = 1'b0;
        vga_source    = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_LOAD: load_en = 1'b1;
            S_COPY: begin
                copy_en  = 1'b1;
                cell_idx = idx;
            end
            S_PRIME: vga_source = 1'b1;
            S_COMPUTE: begin
                compute_en    = 1'b1;
                cell_idx      = idx;
                lookahead_idx = idx + IDX_ONE;
                vga_source    = 1'b1;
            end
            default: ;
        endcase
    end

    // State register and sweep index; index wraps back to 0 after each phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_COPY || state == S_COMPUTE) begin
                idx <= idx + IDX_ONE;
            end else begin
                idx <= '0;
            end
        end
    end

    // Edge detectors for vsync and step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            step_q  <= step;
        end
    end

    // Frame divider, pending single-step request and first-load flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            step_pend <= 1'b0;
            init_pend <= 1'b1;
        end else begin
            if (state == S_LOAD) begin
                frame_cnt <= '0;
                step_pend <= 1'b0;
                init_pend <= 1'b0;
            end else if (idle_tick && !reload_req) begin
                if (!run_n) begin
                    frame_cnt <= (frame_cnt == speed) ? '0 : frame_cnt + FC_ONE;
                end else if (step_pend) begin
                    step_pend <= 1'b0;
                end
            end
            // A fresh step edge is a new request, so it wins over a same-cycle clear.
            if (step_edge && run_n) begin
                step_pend <= 1'b1;
            end
        end
    end

    // Generation and background counters: cleared by a load, advanced when a sweep finishes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            generation <= '0;
            bg_tracker <= 2'd0;
        end else if (state == S_LOAD) begin
            generation <= '0;
            bg_tracker <= 2'd0;
        end else if (state == S_DONE) begin
            generation <= generation + GEN_ONE;
            bg_tracker <= bg_tracker + 2'd1;
        end
    end

endmodule

// File: doc/gol_gen_scheduler.md
Name: gol_gen_scheduler

Overview:
Sequences the Game of Life board update engine from the system clock instead of clocking board logic on vsync. Detects the frame tick from vga_sync's vsync and applies run/pause, single-step, pattern-reload and speed control. On each scheduled generation it drives a burst sweep of cell indices: a copy phase (prev <= curr), then a compute phase with one-cycle neighbour lookahead. Sits between tt_um_game_of_life's user inputs and the board register arrays.

Parameters:
CELL_BITS, 6, log2 of cell count; sweep length is 2**CELL_BITS.
SPEED_BITS, 4, width of the frames-per-generation divider.
GEN_BITS, 16, width of the generation counter.

Ports:
clk  in  1  system/pixel clock, the only clock.
rst_n  in  1  reset, synchronous, active-low.
vsync  in  1  vga_sync vsync, synchronous to clk.
run_n  in  1  level; 0 = free-run, 1 = paused.
step  in  1  level; each rising edge while paused requests one generation.
pattern_rst  in  1  level; reload the start pattern at the next frame tick.
speed  in  SPEED_BITS  generations occur every speed+1 frame ticks.
cell_idx  out  CELL_BITS  cell being written this cycle.
lookahead_idx  out  CELL_BITS  cell whose neighbour count the engine registers this cycle.
load_en  out  1  one-cycle pulse: engine loads start pattern into curr_board.
copy_en  out  1  engine writes prev[cell_idx] <= curr[cell_idx].
compute_en  out  1  engine writes curr[cell_idx] from prev and its registered neighbour count.
vga_source  out  1  display mux select: 0 = curr_board, 1 = prev_board.
generation  out  GEN_BITS  completed generations since last load.
bg_tracker  out  2  background colour offset; increments per generation.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs are 0. frame_cnt=0, step_pend=0, vsync_q=0. init_pend=1, so the first tick after reset forces LOAD.
- tick = vsync & ~vsync_q, where vsync_q is vsync registered on clk. It is used only in IDLE; ticks in any other state are dropped and do not advance frame_cnt.
- step edge: step & ~step_q. It sets step_pend only while run_n=1. step_pend persists until a generation starts or the pattern reloads.
- IDLE, on tick, first match wins:
  - (pattern_rst | init_pend): go to LOAD.
  - run_n=0 and frame_cnt==speed: frame_cnt<=0, go to COPY.
  - run_n=0, otherwise: frame_cnt<=frame_cnt+1.
  - run_n=1 and step_pend: step_pend<=0, go to COPY. frame_cnt is held while paused.
- LOAD (1 cycle): load_en=1. Clears generation, bg_tracker, frame_cnt, step_pend, init_pend and vga_source. Returns to IDLE.
- COPY (2**CELL_BITS cycles):
  - copy_en=1, cell_idx counts 0..max, vga_source=0.
  - After the last index, go to PRIME.
- PRIME (1 cycle): compute_en=0, lookahead_idx=0, vga_source=1. This lets the engine register the neighbour count of cell 0.
- COMPUTE (2**CELL_BITS cycles):
  - compute_en=1, cell_idx counts 0..max, vga_source=1.
  - lookahead_idx = cell_idx+1, wrapping to 0 at max. The engine's registered neighbour count for cell_idx is therefore valid every cycle.
  - After the last index, go to DONE.
- DONE (1 cycle): vga_source<=0, generation<=generation+1 (wraps at all-ones to 0), bg_tracker<=bg_tracker+1 (2-bit wrap). Returns to IDLE.
- lookahead_idx=0 in all states other than PRIME/COMPUTE. cell_idx=0 outside COPY/COMPUTE.
- Sweep length is 2*2**CELL_BITS+2 cycles (130 at default). It completes inside vertical blanking, so vga_source is never 1 during visible lines at 25 MHz.
- run_n, step or pattern_rst changing mid-sweep does not abort the sweep. pattern_rst takes effect at the next IDLE tick.
- rst_n low mid-sweep: immediate return to the reset state on that edge. No further enables are asserted.
- speed changed mid-count: the new value is compared at the next tick. If frame_cnt > speed, it counts up to wrap and then matches.

Test Plan:
1. Reset, run_n=0, speed=0, then 1 vsync pulse -> load_en pulses exactly 1 cycle 1 clk after the tick. generation=0, no copy_en.
2. After load, run_n=0, speed=0, 3 vsync pulses -> each tick starts 64 copy_en cycles (idx 0..63), 1 PRIME cycle, 64 compute_en cycles with lookahead_idx = idx+1 (63→0). Final generation=3, bg_tracker=3, busy high for 130 cycles per tick.
3. speed=2, run_n=0, 9 ticks -> exactly 3 sweeps, starting on ticks 3, 6 and 9.
4. run_n=1, 5 ticks with no step -> no sweeps. Then 1 step rising edge + 2 ticks -> exactly 1 sweep at the first tick; step held high causes no further sweeps.
5. pattern_rst=1 during COMPUTE -> sweep completes, generation increments. Next tick gives LOAD, after which generation=0, bg_tracker=0, vga_source=0.
6. rst_n=0 for 1 cycle at COPY idx 20 -> next cycle all outputs 0, busy=0. The first subsequent tick yields LOAD, not COPY.
